// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: LOAD/STORE/PUSH/POP/CALL/RET onto a 16-bit memory, owns SP.
// Optional overflow/underflow protection via `define STACK_GUARD_EN.
module mem_stage_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 32,
  parameter int SP_RESET     = 2047,
  parameter int STACK_BOTTOM = 1024,
  parameter int MEM_AW       = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] ea,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [31:0]           pc_in,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  rdata_valid,
  output logic [31:0]           pc_out,
  output logic                  pc_valid,
  output logic [ADDR_WIDTH-1:0] sp,
  output logic                  stack_err
);

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_PUSH  = 3'd2;
  localparam logic [2:0] OP_POP   = 3'd3;
  localparam logic [2:0] OP_CALL  = 3'd4;
  localparam logic [2:0] OP_RET   = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] SP_RST  = ADDR_WIDTH'(SP_RESET);
  localparam logic [ADDR_WIDTH:0]   SP_TOP  = (ADDR_WIDTH+1)'(SP_RESET);
  localparam logic [ADDR_WIDTH-1:0] SP_BOT  = ADDR_WIDTH'(STACK_BOTTOM);
  localparam logic [ADDR_WIDTH-1:0] SP_MASK = ADDR_WIDTH'((64'd1 << MEM_AW) - 64'd1);
  localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO     = ADDR_WIDTH'(2);

`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef enum logic {IDLE, SECOND} state_t;

  state_t                state_q, state_d;
  logic                  is_call_q, is_call_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [ADDR_WIDTH-1:0] sp_q, sp_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvld_q, rvld_d;
  logic [31:0]           pc_q, pc_d;
  logic                  pvld_q, pvld_d;

  logic                  we, re, stl;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wd;
  logic [ADDR_WIDTH-1:0] sp_m1, sp_m2, sp_p1, sp_p2;
  logic                  rej_push, rej_call, rej_pop, rej_ret;

  // Unguarded builds keep SP inside the implemented memory so the stack wraps.
  function automatic logic [ADDR_WIDTH-1:0] sp_wrap(input logic [ADDR_WIDTH-1:0] v);
    return GUARD ? v : (v & SP_MASK);
  endfunction

  always_comb begin
    sp_m1 = sp_q - ONE;
    sp_m2 = sp_q - TWO;
    sp_p1 = sp_q + ONE;
    sp_p2 = sp_q + TWO;
    rej_push = GUARD && (sp_q < SP_BOT);
    rej_call = GUARD && (sp_q < SP_BOT + ONE);
    rej_pop  = GUARD && (({1'b0, sp_q} + (ADDR_WIDTH+1)'(1)) > SP_TOP);
    rej_ret  = GUARD && (({1'b0, sp_q} + (ADDR_WIDTH+1)'(2)) > SP_TOP);
  end

  always_comb begin
    state_d   = state_q;
    is_call_d = is_call_q;
    lo_d      = lo_q;
    sp_d      = sp_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rvld_d    = 1'b0;
    pc_d      = pc_q;
    pvld_d    = 1'b0;
    we        = 1'b0;
    re        = 1'b0;
    stl       = 1'b0;
    addr      = '0;
    wd        = '0;
    if (state_q == SECOND) begin
      if (is_call_q) begin
        we   = 1'b1;
        addr = sp_m1;
        wd   = lo_q;
        sp_d = sp_wrap(sp_m2);
      end else begin
        re     = 1'b1;
        addr   = sp_p2;
        pc_d   = 32'({mem_rdata, lo_q});
        pvld_d = 1'b1;
        sp_d   = sp_wrap(sp_p2);
      end
      state_d = IDLE;
    end else if (op_valid) begin
      case (op)
        OP_LOAD: begin
          re      = 1'b1;
          addr    = ea;
          rdata_d = mem_rdata;
          rvld_d  = 1'b1;
        end
        OP_STORE: begin
          we   = 1'b1;
          addr = ea;
          wd   = wdata;
        end
        OP_PUSH: begin
          if (rej_push) err_d = 1'b1;
          else begin
            we   = 1'b1;
            addr = sp_q;
            wd   = wdata;
            sp_d = sp_wrap(sp_m1);
          end
        end
        OP_POP: begin
          if (rej_pop) err_d = 1'b1;
          else begin
            re      = 1'b1;
            addr    = sp_p1;
            rdata_d = mem_rdata;
            rvld_d  = 1'b1;
            sp_d    = sp_wrap(sp_p1);
          end
        end
        OP_CALL: begin
          if (rej_call) err_d = 1'b1;
          else begin
            we        = 1'b1;
            addr      = sp_q;
            wd        = DATA_WIDTH'(pc_in[31:16]);
            lo_d      = DATA_WIDTH'(pc_in[15:0]);
            stl       = 1'b1;
            is_call_d = 1'b1;
            state_d   = SECOND;
          end
        end
        OP_RET: begin
          if (rej_ret) err_d = 1'b1;
          else begin
            re        = 1'b1;
            addr      = sp_p1;
            lo_d      = mem_rdata;
            stl       = 1'b1;
            is_call_d = 1'b0;
            state_d   = SECOND;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      is_call_q <= 1'b0;
      lo_q      <= '0;
      sp_q      <= SP_RST;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rvld_q    <= 1'b0;
      pc_q      <= '0;
      pvld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_call_q <= is_call_d;
      lo_q      <= lo_d;
      sp_q      <= sp_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rvld_q    <= rvld_d;
      pc_q      <= pc_d;
      pvld_q    <= pvld_d;
    end
  end

  // Strobes are gated so a held op cannot reach memory while reset is asserted.
  assign mem_we      = we & rst_n;
  assign mem_re      = re & rst_n;
  assign stall       = stl & rst_n;
  assign mem_addr    = addr;
  assign mem_wdata   = wd;
  assign rdata_out   = rdata_q;
  assign rdata_valid = rvld_q;
  assign pc_out      = pc_q;
  assign pc_valid    = pvld_q;
  assign sp          = sp_q;
  assign stack_err   = GUARD ? err_q : 1'b0;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: stimulus queues expected accesses/results, monitor checks.
module tb_mem_stage_ctrl;
  logic        clk, rst_n;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] ea;
  logic [15:0] wdata;
  logic [31:0] pc_in;
  logic        mem_we, mem_re;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        stall;
  logic [15:0] rdata_out;
  logic        rdata_valid;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [31:0] sp;
  logic        stack_err;

  mem_stage_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .ea(ea), .wdata(wdata),
    .pc_in(pc_in), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall), .rdata_out(rdata_out),
    .rdata_valid(rdata_valid), .pc_out(pc_out), .pc_valid(pc_valid), .sp(sp),
    .stack_err(stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:2047];
  initial for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
  always @(negedge clk) if (mem_we) mem[mem_addr[10:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[10:0]];

  typedef struct { logic wr; logic [31:0] addr; logic [15:0] data; } acc_t;
  acc_t        q_acc[$];
  logic [15:0] q_rd[$];
  logic [31:0] q_pc[$];
  int compared = 0;
  int failed   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic exp_acc(input logic wr, input logic [31:0] a, input logic [15:0] d);
    acc_t e;
    e.wr = wr; e.addr = a; e.data = d;
    q_acc.push_back(e);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we && mem_re) chk("we_re_exclusive", 64'(mem_we & mem_re), 64'd0);
      else if (mem_we || mem_re) begin
        if (q_acc.size() == 0) chk("unexpected_access", {31'd0, mem_we, mem_addr}, 64'd0);
        else begin
          acc_t e;
          e = q_acc.pop_front();
          chk("access", {15'd0, mem_we, mem_addr, (mem_we ? mem_wdata : 16'h0)},
              {15'd0, e.wr, e.addr, e.data});
        end
      end else chk("idle_bus", {16'd0, mem_addr, mem_wdata}, 64'd0);
      if (rdata_valid) begin
        if (q_rd.size() == 0) chk("unexpected_rdata", 64'(rdata_out), 64'hFFFF_FFFF);
        else chk("rdata", 64'(rdata_out), 64'(q_rd.pop_front()));
      end
      if (pc_valid) begin
        if (q_pc.size() == 0) chk("unexpected_pc", 64'(pc_out), 64'hFFFF_FFFF_FFFF);
        else chk("pc_out", 64'(pc_out), 64'(q_pc.pop_front()));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the op's last cycle.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [15:0] d,
                       input logic [31:0] pc, input logic rej);
    logic two;
    two = (o == 3'd4 || o == 3'd5) && !rej;
    op_valid = 1'b1; op = o; ea = a; wdata = d; pc_in = pc;
    @(negedge clk);
    chk("stall_a", 64'(stall), 64'(two));
    @(posedge clk); #1;
    if (two) begin
      @(negedge clk);
      chk("stall_b", 64'(stall), 64'd0);
      @(posedge clk); #1;
    end
    op_valid = 1'b0; op = 3'd7; ea = '0; wdata = '0; pc_in = '0;
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b1; op = 3'd4; ea = '0; wdata = '0; pc_in = 32'h1234_5678;
    #12;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_we_re", 64'({mem_we, mem_re}), 64'd0);
    chk("rst_sp", 64'(sp), 64'd2047);
    chk("rst_valids", 64'({rdata_valid, pc_valid, stack_err}), 64'd0);
    chk("rst_data", 64'({rdata_out, pc_out}), 64'd0);
    op_valid = 1'b0; op = 3'd7;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    exp_acc(1, 2047, 16'h1234);
    issue(3'd2, 0, 16'h1234, 0, 0);
    chk("sp_push", 64'(sp), 64'd2046);
    exp_acc(0, 2047, 0); q_rd.push_back(16'h1234);
    issue(3'd3, 0, 0, 0, 0);
    chk("sp_pop", 64'(sp), 64'd2047);

    exp_acc(1, 5, 16'hBEEF);
    issue(3'd1, 5, 16'hBEEF, 0, 0);
    exp_acc(0, 5, 0); q_rd.push_back(16'hBEEF);
    issue(3'd0, 5, 0, 0, 0);
    chk("sp_ldst", 64'(sp), 64'd2047);

    exp_acc(1, 2047, 16'h0001); exp_acc(1, 2046, 16'h00A4);
    issue(3'd4, 0, 0, 32'h0001_00A4, 0);
    chk("sp_call", 64'(sp), 64'd2045);
    exp_acc(0, 2046, 0); exp_acc(0, 2047, 0); q_pc.push_back(32'h0001_00A4);
    issue(3'd5, 0, 0, 0, 0);
    chk("sp_ret", 64'(sp), 64'd2047);

`ifdef STACK_GUARD_EN
    issue(3'd3, 0, 0, 0, 1);
    chk("guard_pop_sp", 64'(sp), 64'd2047);
    chk("guard_err", 64'(stack_err), 64'd1);
    issue(3'd5, 0, 0, 0, 1);
    chk("guard_ret_sp", 64'(sp), 64'd2047);
    exp_acc(1, 2047, 16'h7777);
    issue(3'd2, 0, 16'h7777, 0, 0);
    chk("guard_push_sp", 64'(sp), 64'd2046);
    chk("guard_err_sticky", 64'(stack_err), 64'd1);
    exp_acc(0, 2047, 0); q_rd.push_back(16'h7777);
    issue(3'd3, 0, 0, 0, 0);
    chk("guard_pop2_sp", 64'(sp), 64'd2047);
`else
    exp_acc(1, 0, 16'h5A5A);
    issue(3'd1, 0, 16'h5A5A, 0, 0);
    exp_acc(0, 2048, 0); q_rd.push_back(16'h5A5A);
    issue(3'd3, 0, 0, 0, 0);
    chk("wrap_pop_sp", 64'(sp), 64'd0);
    exp_acc(1, 0, 16'h7777);
    issue(3'd2, 0, 16'h7777, 0, 0);
    chk("wrap_push_sp", 64'(sp), 64'd2047);
    chk("noguard_err", 64'(stack_err), 64'd0);
`endif

    exp_acc(1, 2047, 16'hDEAD); exp_acc(1, 2046, 16'hBEEF);
    issue(3'd4, 0, 0, 32'hDEAD_BEEF, 0);
    chk("sp_call2", 64'(sp), 64'd2045);
    // RET interrupted by reset in its second cycle: only the first read happens.
    exp_acc(0, 2046, 0);
    op_valid = 1'b1; op = 3'd5;
    @(negedge clk);
    chk("ret_stall_a", 64'(stall), 64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rstB_stall", 64'(stall), 64'd0);
    chk("rstB_re", 64'(mem_re), 64'd0);
    chk("rstB_pvld", 64'(pc_valid), 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd7;
    rst_n = 1'b1;
    chk("rstB_sp", 64'(sp), 64'd2047);
    chk("rstB_err", 64'(stack_err), 64'd0);
    exp_acc(1, 2047, 16'h4321);
    issue(3'd2, 0, 16'h4321, 0, 0);
    chk("post_rst_sp", 64'(sp), 64'd2046);

    for (int i = 0; i < 20; i++) begin
      if (q_acc.size() == 0 && q_rd.size() == 0 && q_pc.size() == 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    chk("queues_drained", 64'(q_acc.size() + q_rd.size() + q_pc.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
